multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit: a Moore state machine that replaces the single-cycle main decoder and sequences each instruction over several cycles on a shared memory/ALU datapath. The supported opcode set is R-type, addi, andi, ori, slti, beq, bne, lw, sw and j. A parameter stretches every memory-access state to cover a configurable memory latency. The block sits between the instruction register (Op), the ALU (Zero) and the datapath multiplexer/enable controls.

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: the opcode and zero flag come in from the datapath, and the mux selects and strobes go back out.
// There is no handshake; every signal is level-valued and is sampled once per clock.
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic       Zero;
  logic       PCEn;
  logic       PCWrite;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluOp;
  logic [1:0] PCSrc;
  logic       Branch;
  logic       Bne;
  logic       ExtOp;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Op, Zero,
    output PCEn, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluOp, PCSrc, Branch, Bne, ExtOp, IllegalOp, State
  );

  modport slave (
    output Op, Zero,
    input  PCEn, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluOp, PCSrc, Branch, Bne, ExtOp, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences each instruction over the shared memory/ALU datapath.
// Memory states (FETCH, MEMRD, MEMWR) stretch by MEM_WAIT cycles using a wait counter.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input logic            clk,
  input logic            reset,
  multicycle_ctrl_if.master ctrl_bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_ITEXE   = 4'd8,
    S_ITWB    = 4'd9,
    S_BEQ     = 4'd10,
    S_BNE     = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_mem;
  logic             w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_done = (r_cnt == CNT_W'(MEM_WAIT));

  // The counter returns to zero on every exit from a memory state, so it is already clear on the next entry.
  always_comb begin
    w_next     = S_FETCH;
    w_cnt_next = '0;
    case (r_state)
      S_FETCH:  w_next = w_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl_bus.Op)
          OP_RTYPE:                         w_next = S_RTEXE;
          OP_LW, OP_SW:                     w_next = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_ITEXE;
          OP_BEQ:                           w_next = S_BEQ;
          OP_BNE:                           w_next = S_BNE;
          OP_J:                             w_next = S_JUMP;
          default:                          w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_next = (ctrl_bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_done ? S_FETCH : S_MEMWR;
      S_RTEXE:  w_next = S_ALUWB;
      S_ITEXE:  w_next = S_ITWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_mem && !w_done) w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_comb begin
    ctrl_bus.PCWrite   = 1'b0;
    ctrl_bus.IorD      = 1'b0;
    ctrl_bus.MemWrite  = 1'b0;
    ctrl_bus.IRWrite   = 1'b0;
    ctrl_bus.RegDst    = 1'b0;
    ctrl_bus.MemToReg  = 1'b0;
    ctrl_bus.RegWrite  = 1'b0;
    ctrl_bus.AluSrcA   = 1'b0;
    ctrl_bus.AluSrcB   = 2'b00;
    ctrl_bus.AluOp     = 3'b010;
    ctrl_bus.PCSrc     = 2'b00;
    ctrl_bus.Branch    = 1'b0;
    ctrl_bus.Bne       = 1'b0;
    ctrl_bus.ExtOp     = 1'b0;
    ctrl_bus.IllegalOp = 1'b0;
    case (r_state)
      S_FETCH: begin
        ctrl_bus.AluSrcB = 2'b01;
        ctrl_bus.PCWrite = w_done;
        ctrl_bus.IRWrite = w_done;
      end
      S_DECODE: begin
        ctrl_bus.AluSrcB = 2'b11;
        ctrl_bus.ExtOp   = 1'b1;
      end
      S_MEMADR: begin
        ctrl_bus.AluSrcA = 1'b1;
        ctrl_bus.AluSrcB = 2'b10;
        ctrl_bus.ExtOp   = 1'b1;
      end
      S_MEMRD: ctrl_bus.IorD = 1'b1;
      S_MEMWB: begin
        ctrl_bus.MemToReg = 1'b1;
        ctrl_bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_bus.IorD     = 1'b1;
        ctrl_bus.MemWrite = 1'b1;
      end
      S_RTEXE: begin
        ctrl_bus.AluSrcA = 1'b1;
        ctrl_bus.AluOp   = 3'b100;
      end
      S_ALUWB: begin
        ctrl_bus.RegDst   = 1'b1;
        ctrl_bus.RegWrite = 1'b1;
      end
      S_ITEXE: begin
        ctrl_bus.AluSrcA = 1'b1;
        ctrl_bus.AluSrcB = 2'b10;
        case (ctrl_bus.Op)
          OP_ANDI: ctrl_bus.AluOp = 3'b000;
          OP_ORI:  ctrl_bus.AluOp = 3'b001;
          OP_SLTI: begin
            ctrl_bus.ExtOp = 1'b1;
            ctrl_bus.AluOp = 3'b111;
          end
          default: ctrl_bus.ExtOp = 1'b1;
        endcase
      end
      S_ITWB: ctrl_bus.RegWrite = 1'b1;
      S_BEQ, S_BNE: begin
        ctrl_bus.AluSrcA = 1'b1;
        ctrl_bus.AluOp   = 3'b110;
        ctrl_bus.PCSrc   = 2'b01;
        ctrl_bus.Branch  = (r_state == S_BEQ);
        ctrl_bus.Bne     = (r_state == S_BNE);
      end
      S_JUMP: begin
        ctrl_bus.PCSrc   = 2'b10;
        ctrl_bus.PCWrite = 1'b1;
      end
      S_ILLEGAL: ctrl_bus.IllegalOp = 1'b1;
      default: ;
    endcase
  end

  assign ctrl_bus.PCEn  = ctrl_bus.PCWrite | (ctrl_bus.Branch & ctrl_bus.Zero) |
                          (ctrl_bus.Bne & ~ctrl_bus.Zero);
  assign ctrl_bus.State = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_WAIT 0 and 2) are driven through directed instruction sequences.
// Per-cycle expected control vectors are queued from an opcode-level model and compared at the falling edge.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic rst0;
  logic rst2;
  int   n_vec;
  int   n_err;
  int   cnt_memwrite;
  int   cnt_irwrite;
  int   cnt_regwrite;
  int   cnt_illegal;
  logic [23:0] exp_q[$];

  multicycle_ctrl_if if0 ();
  multicycle_ctrl_if if2 ();

  multicycle_ctrl #(.MEM_WAIT(0), .CNT_W(4)) dut0 (.clk(clk), .reset(rst0), .ctrl_bus(if0.master));
  multicycle_ctrl #(.MEM_WAIT(2), .CNT_W(4)) dut2 (.clk(clk), .reset(rst2), .ctrl_bus(if2.master));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {State[3:0], PCEn, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemToReg,
  //                 RegWrite, AluSrcA, AluSrcB[1:0], AluOp[2:0], PCSrc[1:0], Branch, Bne, ExtOp, IllegalOp}
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input int cnt, input int w,
                                          input logic [5:0] op, input logic zero);
    logic pcwrite = 1'b0, iord = 1'b0, memwrite = 1'b0, irwrite = 1'b0;
    logic regdst = 1'b0, memtoreg = 1'b0, regwrite = 1'b0, srca = 1'b0;
    logic branch = 1'b0, bne = 1'b0, extop = 1'b0, ill = 1'b0, pcen;
    logic [1:0] srcb = 2'b00;
    logic [1:0] pcsrc = 2'b00;
    logic [2:0] aluop = 3'b010;
    case (st)
      4'd0: begin srcb = 2'b01; if (cnt == w) begin pcwrite = 1'b1; irwrite = 1'b1; end end
      4'd1: begin srcb = 2'b11; extop = 1'b1; end
      4'd2: begin srca = 1'b1; srcb = 2'b10; extop = 1'b1; end
      4'd3: iord = 1'b1;
      4'd4: begin memtoreg = 1'b1; regwrite = 1'b1; end
      4'd5: begin iord = 1'b1; memwrite = 1'b1; end
      4'd6: begin srca = 1'b1; aluop = 3'b100; end
      4'd7: begin regdst = 1'b1; regwrite = 1'b1; end
      4'd8: begin
        srca = 1'b1; srcb = 2'b10;
        if (op == OP_ANDI) aluop = 3'b000;
        else if (op == OP_ORI) aluop = 3'b001;
        else if (op == OP_SLTI) begin aluop = 3'b111; extop = 1'b1; end
        else extop = 1'b1;
      end
      4'd9: regwrite = 1'b1;
      4'd10: begin srca = 1'b1; aluop = 3'b110; pcsrc = 2'b01; branch = 1'b1; end
      4'd11: begin srca = 1'b1; aluop = 3'b110; pcsrc = 2'b01; bne = 1'b1; end
      4'd12: begin pcsrc = 2'b10; pcwrite = 1'b1; end
      4'd13: ill = 1'b1;
      default: ;
    endcase
    pcen = pcwrite | (branch & zero) | (bne & ~zero);
    return {st, pcen, pcwrite, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
            srca, srcb, aluop, pcsrc, branch, bne, extop, ill};
  endfunction

  function automatic logic [23:0] obs_vec(input int which);
    if (which == 0)
      return {if0.State, if0.PCEn, if0.PCWrite, if0.IorD, if0.MemWrite, if0.IRWrite, if0.RegDst,
              if0.MemToReg, if0.RegWrite, if0.AluSrcA, if0.AluSrcB, if0.AluOp, if0.PCSrc,
              if0.Branch, if0.Bne, if0.ExtOp, if0.IllegalOp};
    return {if2.State, if2.PCEn, if2.PCWrite, if2.IorD, if2.MemWrite, if2.IRWrite, if2.RegDst,
            if2.MemToReg, if2.RegWrite, if2.AluSrcA, if2.AluSrcB, if2.AluOp, if2.PCSrc,
            if2.Branch, if2.Bne, if2.ExtOp, if2.IllegalOp};
  endfunction

  // Driver tasks
  task automatic drive(input int which, input logic [5:0] op, input logic zero);
    if (which == 0) begin if0.Op = op; if0.Zero = zero; end
    else begin if2.Op = op; if2.Zero = zero; end
  endtask

  task automatic push_seq(input logic [5:0] op, input int w, input logic zero);
    for (int c = 0; c <= w; c++) exp_q.push_back(exp_vec(4'd0, c, w, op, zero));
    exp_q.push_back(exp_vec(4'd1, 0, w, op, zero));
    case (op)
      OP_R: begin
        exp_q.push_back(exp_vec(4'd6, 0, w, op, zero));
        exp_q.push_back(exp_vec(4'd7, 0, w, op, zero));
      end
      OP_LW: begin
        exp_q.push_back(exp_vec(4'd2, 0, w, op, zero));
        for (int c = 0; c <= w; c++) exp_q.push_back(exp_vec(4'd3, c, w, op, zero));
        exp_q.push_back(exp_vec(4'd4, 0, w, op, zero));
      end
      OP_SW: begin
        exp_q.push_back(exp_vec(4'd2, 0, w, op, zero));
        for (int c = 0; c <= w; c++) exp_q.push_back(exp_vec(4'd5, c, w, op, zero));
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        exp_q.push_back(exp_vec(4'd8, 0, w, op, zero));
        exp_q.push_back(exp_vec(4'd9, 0, w, op, zero));
      end
      OP_BEQ:  exp_q.push_back(exp_vec(4'd10, 0, w, op, zero));
      OP_BNE:  exp_q.push_back(exp_vec(4'd11, 0, w, op, zero));
      OP_J:    exp_q.push_back(exp_vec(4'd12, 0, w, op, zero));
      default: exp_q.push_back(exp_vec(4'd13, 0, w, op, zero));
    endcase
  endtask

  // Scoreboard checks
  task automatic check_vec(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT in FETCH count 0; returns at posedge+1 back in FETCH count 0.
  task automatic run_instr(input int which, input logic [5:0] op, input logic zero,
                           input logic flip, input string tag);
    int w;
    logic [23:0] obs;
    logic [23:0] exp;
    logic [23:0] alt;
    w = (which == 0) ? 0 : 2;
    drive(which, op, zero);
    push_seq(op, w, zero);
    cnt_memwrite = 0; cnt_irwrite = 0; cnt_regwrite = 0; cnt_illegal = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      obs = obs_vec(which);
      exp = exp_q.pop_front();
      check_vec(tag, obs, exp);
      cnt_memwrite += int'(obs[16]);
      cnt_irwrite  += int'(obs[15]);
      cnt_regwrite += int'(obs[12]);
      cnt_illegal  += int'(obs[0]);
      if (flip && (exp[23:20] == 4'd10 || exp[23:20] == 4'd11)) begin
        drive(which, op, ~zero);
        #1;
        alt = exp_vec(exp[23:20], 0, w, op, ~zero);
        obs = obs_vec(which);
        check_int({tag, "_pcen_flip"}, int'(obs[19]), int'(alt[19]));
        drive(which, op, zero);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst0 = 1'b1;
    rst2 = 1'b1;
    drive(0, OP_R, 1'b0);
    drive(2, OP_R, 1'b0);
    #2;
    check_vec("reset_w0", obs_vec(0), exp_vec(4'd0, 0, 0, OP_R, 1'b0));
    check_vec("reset_w2", obs_vec(2), exp_vec(4'd0, 0, 2, OP_R, 1'b0));
    @(posedge clk);
    #1;
    rst0 = 1'b0;

    run_instr(0, OP_R,    1'b0, 1'b0, "w0_rtype");
    run_instr(0, OP_BEQ,  1'b1, 1'b1, "w0_beq_z1");
    run_instr(0, OP_BEQ,  1'b0, 1'b0, "w0_beq_z0");
    run_instr(0, OP_BNE,  1'b0, 1'b1, "w0_bne_z0");
    run_instr(0, OP_BNE,  1'b1, 1'b0, "w0_bne_z1");
    run_instr(0, OP_ANDI, 1'b0, 1'b0, "w0_andi");
    run_instr(0, OP_ADDI, 1'b0, 1'b0, "w0_addi");
    run_instr(0, OP_ORI,  1'b0, 1'b0, "w0_ori");
    run_instr(0, OP_SLTI, 1'b0, 1'b0, "w0_slti");
    run_instr(0, OP_J,    1'b0, 1'b0, "w0_jump");
    run_instr(0, OP_LW,   1'b0, 1'b0, "w0_lw");
    run_instr(0, OP_SW,   1'b0, 1'b0, "w0_sw");
    check_int("w0_sw_memwrite_len", cnt_memwrite, 1);
    run_instr(0, OP_BAD,  1'b0, 1'b0, "w0_illegal");
    check_int("w0_illegal_len", cnt_illegal, 1);
    check_int("w0_illegal_regwrite", cnt_regwrite, 0);
    check_int("w0_illegal_memwrite", cnt_memwrite, 0);
    run_instr(0, 6'($urandom_range(16, 31)), 1'b0, 1'b0, "w0_rand_illegal");

    rst2 = 1'b0;
    run_instr(2, OP_LW,   1'b0, 1'b0, "w2_lw");
    check_int("w2_lw_irwrite_cnt", cnt_irwrite, 1);
    run_instr(2, OP_SW,   1'b0, 1'b0, "w2_sw");
    check_int("w2_sw_memwrite_len", cnt_memwrite, 3);
    check_int("w2_sw_regwrite", cnt_regwrite, 0);
    run_instr(2, OP_ADDI, 1'b0, 1'b0, "w2_addi");
    run_instr(2, OP_BEQ,  1'b1, 1'b1, "w2_beq");

    // Abort a store in MEMWR count 1 with an asynchronous reset.
    drive(2, OP_SW, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check_vec("abort_pre", obs_vec(2), exp_vec(4'd5, 1, 2, OP_SW, 1'b0));
    #2;
    rst2 = 1'b1;
    #1;
    check_int("abort_memwrite", int'(if2.MemWrite), 0);
    check_int("abort_state", int'(if2.State), 0);
    repeat (2) begin
      @(negedge clk);
      check_vec("abort_hold", obs_vec(2), exp_vec(4'd0, 0, 2, OP_SW, 1'b0));
    end
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    run_instr(2, OP_R, 1'b0, 1'b0, "w2_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
